md_unit_ctrl: RTL and testbench
===============================

// Module: md_unit_ctrl
// PURPOSE
//  Multiply/divide sequencer for the EX stage.
//  - Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO issued from the ID/EX register and owns the HI/LO registers.
//  - Models the fixed multi-cycle latency and drives the stall request that freezes IF/ID and flushes ID/EX
//    while a later HI/LO-dependent instruction waits.
// PARAMETERS
//  DATA_W       32  operand / HI / LO width
//  MULT_CYCLES  5   busy cycles for MULT/MULTU (>=1)
//  DIV_CYCLES   10  busy cycles for DIV/DIVU (>=1)
// PORTS
//  clk        in   1       single clock, rising edge
//  reset      in   1       synchronous, active-low (0 = reset at next rising edge)
//  start      in   1       EX-stage instruction is an md op this cycle
//  op         in   3       md_op_t: MULT=0 MULTU=1 DIV=2 DIVU=3 MTHI=4 MTLO=5 (6,7 = no-op)
//  rs_val     in   DATA_W  forwarded rs operand
//  rt_val     in   DATA_W  forwarded rt operand
//  d_uses_md  in   1       ID-stage instruction is md op or MFHI/MFLO
//  busy       out  1       multi-cycle operation in flight
//  stall      out  1       hold IF/ID, flush ID/EX (combinational)
//  hi         out  DATA_W  HI register
//  lo         out  DATA_W  LO register
//  done       out  1       one-cycle pulse after HI/LO commit
// BEHAVIOUR
//  - Reset: state=IDLE, cnt=0, busy=0, done=0, hi=0, lo=0, pending results=0.
//  - Reset wins over every other input, including a cycle with an op in flight; the in-flight op is discarded.
//  - States:
//    - IDLE: on start & op∈{MULT,MULTU,DIV,DIVU}:
//      - latch result into pend_hi/pend_lo;
//      - cnt <= MULT_CYCLES or DIV_CYCLES;
//      - go to RUN.
//    - RUN: cnt decrements each cycle.
//      - When cnt==1: hi<=pend_hi, lo<=pend_lo, go to IDLE, done<=1 next cycle.
//  - busy = (state==RUN); it is high for exactly N cycles, beginning the cycle after the start cycle.
//  - stall = d_uses_md & (busy | (start & op<=DIVU)).
//  - MTHI/MTLO: in IDLE with start, write hi/lo <= rs_val at that edge and set no busy. Ignored while busy;
//    the pipeline guarantees this never happens, and the bench checks it.
//  - start while busy: ignored entirely, no state change.
//  - Arithmetic:
//    - MULT: {hi,lo} = signed 64-bit rs*rt.
//    - MULTU: unsigned 64-bit rs*rt.
//    - DIV: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
//    - DIVU: unsigned quotient and remainder.
//    - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
//    - Divide by zero: the full latency still runs, and hi/lo are left unchanged at commit.
//  - done: asserted only the cycle after commit; deasserted by reset.
//  - Back-to-back: start in the same cycle IDLE is re-entered (cnt==1 commit edge has passed) is accepted
//    normally; no bubble is required.
// STRUCTURE
//  - Package md_pkg holds:
//    - md_op_t encodings;
//    - MULT_CYCLES_DEF=5, DIV_CYCLES_DEF=10;
//    - state enum {IDLE,RUN}.
//  - One combinational sub-module, md_arith, takes (op, rs, rt) and returns {res_hi, res_lo, div_zero}.
//  - FSM, counter, HI/LO and stall logic live in md_unit_ctrl.
// TESTING
//  1. MULT rs=0xFFFFFFFE(-2), rt=3 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA; done pulse 1 cycle.
//  2. DIVU rs=100, rt=7 -> busy 10 cycles; then lo=14, hi=2. DIV rs=-7, rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//  3. DIV with rt=0 after hi=0x11, lo=0x22 -> busy 10 cycles; hi/lo stay 0x11/0x22.
//  4. MULT start with d_uses_md=1 -> stall=1 in the start cycle and all 5 busy cycles; 0 the cycle after.
//     With d_uses_md=0 -> stall=0 throughout.
//  5. MTLO rs=0xABCD in IDLE -> lo=0xABCD next cycle, busy never rises.
//     MTHI issued while busy -> hi unchanged (assertion fires).
//  6. reset=0 on the 3rd busy cycle of DIV -> next cycle busy=0, hi=lo=0, done=0, state IDLE.
//     A subsequent MULTU 0xFFFFFFFF*2 gives hi=1, lo=0xFFFFFFFE.

Source files
------------

// File: rtl/md_pkg.sv
// Shared encodings and defaults for the multiply/divide unit.
package md_pkg;

   typedef enum logic [2:0] {
      OP_MULT  = 3'd0,
      OP_MULTU = 3'd1,
      OP_DIV   = 3'd2,
      OP_DIVU  = 3'd3,
      OP_MTHI  = 3'd4,
      OP_MTLO  = 3'd5,
      OP_NOP6  = 3'd6,
      OP_NOP7  = 3'd7
   } md_op_t;

   localparam int MULT_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF  = 10;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } md_state_t;

   // True for the four ops that occupy the unit for multiple cycles.
   function automatic logic is_long_op(input logic [2:0] op);
      return (op <= OP_DIVU);
   endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath producing the HI/LO pair for one op.
module md_arith
   import md_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [2:0]        op,
   input  logic [DATA_W-1:0] rs,
   input  logic [DATA_W-1:0] rt,
   output logic [DATA_W-1:0] res_hi,
   output logic [DATA_W-1:0] res_lo,
   output logic              div_zero
);

   logic [2*DATA_W-1:0] rs_sx, rt_sx, rs_zx, rt_zx;
   logic [2*DATA_W-1:0] prod_s, prod_u;
   logic [DATA_W-1:0]   divisor, mag_a, mag_b, q_mag, r_mag;
   logic [DATA_W-1:0]   q_u, r_u, q_s, r_s;
   logic                rs_neg, rt_neg, rt_zero;

   // Products, unsigned and magnitude-based signed division, then op select.
   // Signed division works on magnitudes so 0x80000000 / -1 wraps to 0x80000000
   // with zero remainder without a special case.
   always_comb begin
      rs_sx   = {{DATA_W{rs[DATA_W-1]}}, rs};
      rt_sx   = {{DATA_W{rt[DATA_W-1]}}, rt};
      rs_zx   = {{DATA_W{1'b0}}, rs};
      rt_zx   = {{DATA_W{1'b0}}, rt};
      prod_s  = rs_sx * rt_sx;
      prod_u  = rs_zx * rt_zx;

      rt_zero = (rt == '0);
      divisor = rt_zero ? DATA_W'(1) : rt;
      q_u     = rs / divisor;
      r_u     = rs % divisor;

      rs_neg  = rs[DATA_W-1];
      rt_neg  = divisor[DATA_W-1];
      mag_a   = rs_neg ? (~rs + DATA_W'(1)) : rs;
      mag_b   = rt_neg ? (~divisor + DATA_W'(1)) : divisor;
      q_mag   = mag_a / mag_b;
      r_mag   = mag_a % mag_b;
      q_s     = (rs_neg ^ rt_neg) ? (~q_mag + DATA_W'(1)) : q_mag;
      r_s     = rs_neg ? (~r_mag + DATA_W'(1)) : r_mag;

      res_hi   = '0;
      res_lo   = '0;
      div_zero = 1'b0;
      case (op)
         OP_MULT:  {res_hi, res_lo} = prod_s;
         OP_MULTU: {res_hi, res_lo} = prod_u;
         OP_DIV: begin
            res_hi   = r_s;
            res_lo   = q_s;
            div_zero = rt_zero;
         end
         OP_DIVU: begin
            res_hi   = r_u;
            res_lo   = q_u;
            div_zero = rt_zero;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/md_unit_ctrl.sv
// Multiply/divide sequencer: owns HI/LO, models op latency, raises pipeline stall.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  ST_IDLE | ready; accepts long ops and MTHI/MTLO writes
//  ST_RUN  | long op in flight; cnt counts down, commit to HI/LO at cnt==1
module md_unit_ctrl
   import md_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [2:0]        op,
   input  logic [DATA_W-1:0] rs_val,
   input  logic [DATA_W-1:0] rt_val,
   input  logic              d_uses_md,
   output logic              busy,
   output logic              stall,
   output logic [DATA_W-1:0] hi,
   output logic [DATA_W-1:0] lo,
   output logic              done
);

   localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);

   md_state_t         state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
   logic              pend_zero_q, pend_zero_d;
   logic [DATA_W-1:0] hi_q, hi_d, lo_q, lo_d;
   logic              done_q, done_d;

   logic [DATA_W-1:0] res_hi, res_lo;
   logic              div_zero;

   md_arith #(.DATA_W(DATA_W)) u_arith (
      .op       (op),
      .rs       (rs_val),
      .rt       (rt_val),
      .res_hi   (res_hi),
      .res_lo   (res_lo),
      .div_zero (div_zero)
   );

   // Next-state: launch/countdown/commit, plus direct HI/LO moves when idle.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      pend_hi_d   = pend_hi_q;
      pend_lo_d   = pend_lo_q;
      pend_zero_d = pend_zero_q;
      hi_d        = hi_q;
      lo_d        = lo_q;
      done_d      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               case (op)
                  OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                     pend_hi_d   = res_hi;
                     pend_lo_d   = res_lo;
                     pend_zero_d = div_zero;
                     cnt_d       = ((op == OP_MULT) || (op == OP_MULTU)) ?
                                   CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                     state_d     = ST_RUN;
                  end
                  OP_MTHI: hi_d = rs_val;
                  OP_MTLO: lo_d = rs_val;
                  default: ;
               endcase
            end
         end
         ST_RUN: begin
            if (cnt_q == CNT_W'(1)) begin
               if (!pend_zero_q) begin
                  hi_d = pend_hi_q;
                  lo_d = pend_lo_q;
               end
               cnt_d   = '0;
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State registers; synchronous active-low reset discards any op in flight.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         pend_hi_q   <= '0;
         pend_lo_q   <= '0;
         pend_zero_q <= 1'b0;
         hi_q        <= '0;
         lo_q        <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         pend_hi_q   <= pend_hi_d;
         pend_lo_q   <= pend_lo_d;
         pend_zero_q <= pend_zero_d;
         hi_q        <= hi_d;
         lo_q        <= lo_d;
         done_q      <= done_d;
      end
   end

   assign busy  = (state_q == ST_RUN);
   assign stall = d_uses_md & (busy | (start & is_long_op(op)));
   assign hi    = hi_q;
   assign lo    = lo_q;
   assign done  = done_q;

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Directed bench for md_unit_ctrl.
module tb_md_unit_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        d_uses_md;
   logic        busy;
   logic        stall;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        done;

   int checks = 0;
   int errors = 0;

   md_unit_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .op        (op),
      .rs_val    (rs_val),
      .rt_val    (rt_val),
      .d_uses_md (d_uses_md),
      .busy      (busy),
      .stall     (stall),
      .hi        (hi),
      .lo        (lo),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Issue one long op, track busy length and stall, check committed result.
   // Returns positioned in the cycle after commit (done expected high).
   task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input int n_exp, input logic [31:0] hi_exp,
                         input logic [31:0] lo_exp, input logic stall_exp);
      int n;
      start  = 1'b1;
      op     = o;
      rs_val = a;
      rt_val = b;
      #1;
      chk({tag, " stall_start"}, stall, stall_exp);
      cycle();
      start = 1'b0;
      op    = 3'd7;
      #1;
      n = 0;
      while (busy === 1'b1 && n < 40) begin
         n++;
         chk({tag, " stall_busy"}, stall, stall_exp);
         cycle();
      end
      chk({tag, " busy_len"}, n, n_exp);
      chk({tag, " hi"}, hi, hi_exp);
      chk({tag, " lo"}, lo, lo_exp);
      chk({tag, " done"}, done, 1'b1);
   endtask

   initial begin
      int k;
      reset     = 1'b0;
      start     = 1'b0;
      op        = 3'd7;
      rs_val    = '0;
      rt_val    = '0;
      d_uses_md = 1'b0;
      cycle();
      cycle();
      chk("rst busy", busy, 1'b0);
      chk("rst hi", hi, 32'h0);
      chk("rst lo", lo, 32'h0);
      chk("rst done", done, 1'b0);
      chk("rst stall", stall, 1'b0);
      reset = 1'b1;
      cycle();

      // signed multiply
      run_op("mult", 3'd0, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
      cycle();
      chk("mult done_clear", done, 1'b0);

      // DIVU, then back-to-back DIV issued in the done cycle
      run_op("divu", 3'd3, 32'd100, 32'd7, 10, 32'd2, 32'd14, 1'b0);
      run_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
      cycle();
      run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0, 32'h8000_0000, 1'b0);
      cycle();
      run_op("multu", 3'd1, 32'hFFFF_FFFE, 32'd3, 5, 32'd2, 32'hFFFF_FFFA, 1'b0);
      cycle();

      // divide by zero leaves HI/LO untouched
      start = 1'b1; op = 3'd4; rs_val = 32'h11;
      cycle();
      start = 1'b0;
      chk("mthi hi", hi, 32'h11);
      start = 1'b1; op = 3'd5; rs_val = 32'h22;
      cycle();
      start = 1'b0;
      chk("mtlo lo", lo, 32'h22);
      run_op("div0", 3'd2, 32'd5, 32'd0, 10, 32'h11, 32'h22, 1'b0);
      cycle();

      // MTLO in idle: immediate write, no busy
      start = 1'b1; op = 3'd5; rs_val = 32'hABCD;
      cycle();
      start = 1'b0; op = 3'd7;
      chk("mtlo2 lo", lo, 32'hABCD);
      chk("mtlo2 hi", hi, 32'h11);
      chk("mtlo2 busy", busy, 1'b0);
      cycle();
      chk("mtlo2 busy_later", busy, 1'b0);

      // stall behaviour with and without a dependent ID instruction
      d_uses_md = 1'b1;
      run_op("stall1", 3'd0, 32'd3, 32'd4, 5, 32'd0, 32'd12, 1'b1);
      chk("stall1 after", stall, 1'b0);
      cycle();
      d_uses_md = 1'b0;
      run_op("stall0", 3'd0, 32'd7, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b0);
      cycle();

      // MTHI while busy is ignored
      start = 1'b1; op = 3'd0; rs_val = 32'd3; rt_val = 32'd4;
      cycle();
      start = 1'b0;
      cycle();
      start = 1'b1; op = 3'd4; rs_val = 32'hDEAD;
      cycle();
      start = 1'b0; op = 3'd7;
      chk("mthi_busy hi", hi, 32'hFFFF_FFFF);
      chk("mthi_busy busy", busy, 1'b1);
      k = 0;
      while (busy === 1'b1 && k < 40) begin
         k++;
         cycle();
      end
      chk("mthi_busy wait", k, 3);
      chk("mthi_busy hi_final", hi, 32'd0);
      chk("mthi_busy lo_final", lo, 32'd12);
      cycle();

      // reset during third busy cycle of DIV
      start = 1'b1; op = 3'd2; rs_val = 32'd100; rt_val = 32'd7;
      cycle();
      start = 1'b0; op = 3'd7;
      cycle();
      cycle();
      chk("rst_mid busy_before", busy, 1'b1);
      reset = 1'b0;
      cycle();
      chk("rst_mid busy", busy, 1'b0);
      chk("rst_mid hi", hi, 32'h0);
      chk("rst_mid lo", lo, 32'h0);
      chk("rst_mid done", done, 1'b0);
      reset = 1'b1;
      cycle();
      chk("rst_mid discarded", busy, 1'b0);
      cycle();
      chk("rst_mid lo_stays", lo, 32'h0);
      run_op("multu_post", 3'd1, 32'hFFFF_FFFF, 32'd2, 5, 32'd1, 32'hFFFF_FFFE, 1'b0);
      cycle();
      chk("multu_post done_clear", done, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
